// File: rtl/conv1d_seq_ctrl.sv
`default_nettype none
// conv1d_seq_ctrl -- bit-serial GF(2) 1-D convolution sequencer with a valid/ready result stream
// rev 1.0
module conv1d_seq_ctrl #(
  parameter int INLEN   = 16,
  parameter int KERNLEN = 3,
  localparam int OUTLEN = INLEN + KERNLEN - 1,
  localparam int IDXW   = (OUTLEN > 1) ? $clog2(OUTLEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [INLEN-1:0]  in,
  input  logic [KERNLEN-1:0] kernel,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic [IDXW-1:0]   out_idx,
  output logic [OUTLEN-1:0] out,
  output logic              done
);

  localparam int              PADW     = OUTLEN + KERNLEN - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(OUTLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [INLEN-1:0]   in_q;
  logic [KERNLEN-1:0] kern_q;
  logic [KERNLEN-1:0] kern_rev;
  logic [PADW-1:0]    pad;
  logic [KERNLEN-1:0] win;
  logic [IDXW-1:0]    calc_idx;
  logic               calc_bit;
  logic               handshake;
  logic               last;
  logic               capture;

  // Zero-padded input; window i covers a[i +: KERNLEN] against the reversed kernel.
  assign pad       = PADW'(in_q) << (KERNLEN - 1);
  assign kern_rev  = {<<{kern_q}};
  assign calc_idx  = out_valid ? out_idx + 1'b1 : '0;
  assign win       = KERNLEN'(pad >> calc_idx);
  assign calc_bit  = ^(win & kern_rev);

  assign handshake = (state == RUN) && out_valid && out_ready;
  assign last      = (out_idx == LAST_IDX);
  assign capture   = (state == IDLE) && start && !abort;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (handshake && last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= '0;
      kern_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state_next == DONE);
      if (capture) begin
        in_q      <= in;
        kern_q    <= kernel;
        out       <= '0;
        out_valid <= 1'b0;
        out_idx   <= '0;
      end else if (abort) begin
        out_valid <= 1'b0;
      end else if (state == RUN) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_idx   <= '0;
          out_bit   <= calc_bit;
        end else if (out_ready) begin
          out[out_idx] <= out_bit;
          if (last) begin
            out_valid <= 1'b0;
          end else begin
            out_idx <= out_idx + 1'b1;
            out_bit <= calc_bit;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_seq_ctrl.sv
`default_nettype none
// tb_conv1d_seq_ctrl -- directed and random jobs against a GF(2) polynomial-product reference
// rev 1.0
module tb_conv1d_seq_ctrl;

  localparam int IL = 4;
  localparam int KL = 3;
  localparam int OL = IL + KL - 1;
  localparam int IW = $clog2(OL);
  localparam int BL = 16;
  localparam int BO = BL + KL - 1;
  localparam int BW = $clog2(BO);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, abort, out_ready;
  logic [IL-1:0] in_v;
  logic [KL-1:0] kern_v;
  logic          busy, out_valid, out_bit, done;
  logic [IW-1:0] out_idx;
  logic [OL-1:0] out_w;

  logic          b_start, b_abort, b_ready;
  logic [BL-1:0] b_in;
  logic [KL-1:0] b_kern;
  logic          b_busy, b_valid, b_bit, b_done;
  logic [BW-1:0] b_idx;
  logic [BO-1:0] b_out;

  conv1d_seq_ctrl #(.INLEN(IL), .KERNLEN(KL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in(in_v), .kernel(kern_v),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_idx(out_idx), .out(out_w), .done(done)
  );

  conv1d_seq_ctrl #(.INLEN(BL), .KERNLEN(KL)) dut_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .in(b_in), .kernel(b_kern),
    .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready), .out_bit(b_bit),
    .out_idx(b_idx), .out(b_out), .done(b_done)
  );

  typedef struct {
    int   idx;
    logic b;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] gf_mul(input logic [31:0] a, input logic [31:0] k, input int kl);
    logic [63:0] r;
    r = '0;
    for (int m = 0; m < kl; m++) begin
      if (k[m]) r = r ^ (64'(a) << m);
    end
    return r;
  endfunction

  // Called at a falling edge; leaves the bench at the falling edge after the capture edge.
  task automatic start_job(input logic [IL-1:0] i, input logic [KL-1:0] k, output logic [63:0] r);
    r = gf_mul(32'(i), 32'(k), KL);
    for (int n = 0; n < OL; n++) sb.push_back('{n, r[n]});
    in_v   = i;
    kern_v = k;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int mode, input int abort_after, input int pulse_at,
                       output int hs, output int dones, output int done_c);
    bit aborted;
    bit idle_seen;
    aborted   = 1'b0;
    idle_seen = 1'b0;
    hs = 0;
    dones = 0;
    done_c = -1;
    for (int c = 0; c < 200; c++) begin
      abort = 1'b0;
      start = 1'b0;
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
      out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      if (c == pulse_at) begin
        start  = 1'b1;
        in_v   = ~in_v;
        kern_v = ~kern_v;
      end
      if (abort_after >= 0 && !aborted && hs == abort_after + 1) begin
        abort     = 1'b1;
        out_ready = 1'b0;
        aborted   = 1'b1;
      end
      if (done) begin
        dones++;
        done_c = c;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'(out_valid), 64'(0));
        end else begin
          check("out_idx", 64'(out_idx), 64'(sb[0].idx));
          check("out_bit", 64'(out_bit), 64'(sb[0].b));
          if (out_ready) begin
            void'(sb.pop_front());
            hs++;
          end
        end
      end
      @(negedge clk);
    end
    check("job_terminates", 64'(idle_seen), 64'(1));
  endtask

  initial begin
    logic [63:0] r;
    int hs, dn, dc;
    bit seen;

    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; out_ready = 1'b0; in_v = '0; kern_v = '0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1; b_in = '0; b_kern = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_idx", 64'(out_idx), 64'(0));
    check("rst_out", 64'(out_w), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Ready held high: one bit per cycle, done right after the last handshake.
    start_job(4'b1011, 3'b011, r);
    drain(0, -1, -1, hs, dn, dc);
    check("t1_hs", 64'(hs), 64'(OL));
    check("t1_done_cnt", 64'(dn), 64'(1));
    check("t1_latency", 64'(dc), 64'(OL + 1));
    check("t1_out", 64'(out_w), 64'h1D);
    check("t1_idle_busy", 64'(busy), 64'(0));

    // Ready toggling: bits held during stalls.
    start_job(4'b1011, 3'b011, r);
    drain(1, -1, -1, hs, dn, dc);
    check("t2_hs", 64'(hs), 64'(OL));
    check("t2_done_cnt", 64'(dn), 64'(1));
    check("t2_out", 64'(out_w), 64'h1D);

    // Zero kernel, then a back-to-back job started on the first IDLE edge.
    start_job(4'b1111, 3'b000, r);
    drain(0, -1, -1, hs, dn, dc);
    check("t3a_out", 64'(out_w), 64'h00);
    check("t3a_done_cnt", 64'(dn), 64'(1));
    start_job(4'b0001, 3'b111, r);
    drain(0, -1, -1, hs, dn, dc);
    check("t3b_out", 64'(out_w), 64'h07);
    check("t3b_done_cnt", 64'(dn), 64'(1));

    // start re-pulsed mid-run with different operands is ignored.
    start_job(4'b1011, 3'b011, r);
    drain(0, -1, 2, hs, dn, dc);
    check("t4_out", 64'(out_w), 64'h1D);
    check("t4_hs", 64'(hs), 64'(OL));

    // Abort after idx 2 is accepted; bits 0..2 remain, no done pulse.
    start_job(4'b1011, 3'b011, r);
    drain(0, 2, -1, hs, dn, dc);
    check("t5_hs", 64'(hs), 64'(3));
    check("t5_done_cnt", 64'(dn), 64'(0));
    check("t5_valid", 64'(out_valid), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_done", 64'(done), 64'(0));
    check("t5_out_kept", 64'(out_w), 64'h05);
    sb.delete();
    start_job(4'b0110, 3'b101, r);
    drain(0, -1, -1, hs, dn, dc);
    check("t5_fresh_out", 64'(out_w), r);
    check("t5_fresh_out_const", 64'(out_w), 64'h1E);
    check("t5_fresh_done_cnt", 64'(dn), 64'(1));

    // abort together with start in IDLE: nothing captured.
    abort = 1'b1; start = 1'b1; in_v = 4'b1111; kern_v = 3'b111;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("t5_abort_start_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("t5_abort_start_out", 64'(out_w), 64'h1E);

    // Async reset while a bit is being offered.
    start_job(4'b1011, 3'b011, r);
    out_ready = 1'b0;
    @(negedge clk);
    check("t6_pre_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_valid", 64'(out_valid), 64'(0));
    check("t6_bit", 64'(out_bit), 64'(0));
    check("t6_idx", 64'(out_idx), 64'(0));
    check("t6_out", 64'(out_w), 64'(0));
    check("t6_done", 64'(done), 64'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random 16-bit jobs on the wide instance.
    for (int j = 0; j < 1000; j++) begin
      b_in   = BL'($urandom);
      b_kern = KL'($urandom);
      r      = gf_mul(32'(b_in), 32'(b_kern), KL);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (b_done) begin
          seen = 1'b1;
          break;
        end
      end
      check("big_done", 64'(seen), 64'(1));
      check("big_out", 64'(b_out), r);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
